// File: rtl/cache_pkg.sv
// Shared cache definitions: transfer-engine state encoding and block geometry
// used by both the engine and the cache index/offset math.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int BLOCK_WORDS_DEFAULT = 4;
  localparam int CNT_BITS            = $clog2(BLOCK_WORDS_DEFAULT);
  localparam int OFF_BITS            = CNT_BITS + 2;

endpackage

// File: rtl/cache_line_xfer_if.sv
// Word-wide req/ack memory port between the block-transfer engine (master)
// and the memory side (slave).
interface cache_line_xfer_if #(
  parameter int ADDR_W = 32
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ack;
  logic [31:0]       rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/cache_line_xfer.sv
// Block-transfer engine below the data cache: optional word-by-word writeback
// of a dirty victim, then word-by-word refill, ending in a one-cycle done pulse.
module cache_line_xfer
  import cache_pkg::*;
#(
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEFAULT,
  parameter int ADDR_W      = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     need_wb,
  input  logic [ADDR_W-1:0]        victim_addr,
  input  logic [32*BLOCK_WORDS-1:0] victim_data,
  input  logic [ADDR_W-1:0]        fill_addr,
  output logic                     busy,
  output logic                     done,
  output logic [32*BLOCK_WORDS-1:0] fill_data,
  cache_line_xfer_if.master        mem
);

  localparam int CNT_W  = $clog2(BLOCK_WORDS);
  localparam int OFF    = CNT_W + 2;
  localparam int BASE_W = ADDR_W - OFF;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_WORDS - 1);

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [BASE_W-1:0]          vbase_q, vbase_d;
  logic [BASE_W-1:0]          fbase_q, fbase_d;
  logic [32*BLOCK_WORDS-1:0]  vdata_q, vdata_d;
  logic [32*BLOCK_WORDS-1:0]  fill_data_q, fill_data_d;
  logic                       unused_addr_lsbs;

  // Block offset bits of the incoming addresses are irrelevant: beats rebuild them from cnt.
  assign unused_addr_lsbs = ^{victim_addr[OFF-1:0], fill_addr[OFF-1:0]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vbase_d     = vbase_q;
    fbase_d     = fbase_q;
    vdata_d     = vdata_q;
    fill_data_d = fill_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          vbase_d = victim_addr[ADDR_W-1:OFF];
          fbase_d = fill_addr[ADDR_W-1:OFF];
          vdata_d = victim_data;
          cnt_d   = '0;
          state_d = need_wb ? WB : FILL;
        end
      end
      WB: begin
        if (mem.ack) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (mem.ack) begin
          fill_data_d[{cnt_q, 5'b0} +: 32] = mem.rdata;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      vbase_q     <= '0;
      fbase_q     <= '0;
      vdata_q     <= '0;
      fill_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vbase_q     <= vbase_d;
      fbase_q     <= fbase_d;
      vdata_q     <= vdata_d;
      fill_data_q <= fill_data_d;
    end
  end

  // Memory port is decoded purely from registered state, so it holds steady while waiting
  // for ack and drops as soon as reset clears the state.
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign fill_data = fill_data_q;
  assign mem.req   = (state_q == WB) || (state_q == FILL);
  assign mem.we    = (state_q == WB);
  assign mem.addr  = (state_q == WB)   ? {vbase_q, cnt_q, 2'b00} :
                     (state_q == FILL) ? {fbase_q, cnt_q, 2'b00} : '0;
  assign mem.wdata = (state_q == WB) ? vdata_q[{cnt_q, 5'b0} +: 32] : '0;

endmodule

// File: tb/tb_cache_line_xfer.sv
// Scoreboard bench for cache_line_xfer: stimulus queues expected memory beats and
// filled blocks, an independent monitor checks every beat and done pulse.
module tb_cache_line_xfer;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic         need_wb;
  logic [31:0]  victim_addr;
  logic [127:0] victim_data;
  logic [31:0]  fill_addr;
  logic         busy;
  logic         done;
  logic [127:0] fill_data;

  cache_line_xfer_if #(.ADDR_W(32)) mem_bus ();

  cache_line_xfer #(.BLOCK_WORDS(4), .ADDR_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .need_wb     (need_wb),
    .victim_addr (victim_addr),
    .victim_data (victim_data),
    .fill_addr   (fill_addr),
    .busy        (busy),
    .done        (done),
    .fill_data   (fill_data),
    .mem         (mem_bus.master)
  );

  beat_t        exp_beats[$];
  logic [127:0] exp_fill[$];
  logic [31:0]  rd_tbl[4];
  int           ack_mode;
  int           vectors;
  int           miscompares;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic finishRun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  // Memory model: ack pattern per mode, read data looked up by the word index of the beat.
  initial begin : memory_model
    int cyc;
    cyc = 0;
    mem_bus.ack   = 1'b0;
    mem_bus.rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (ack_mode)
        0:       mem_bus.ack = 1'b1;
        1:       mem_bus.ack = (cyc % 3 == 0);
        default: mem_bus.ack = 1'b0;
      endcase
      mem_bus.rdata = rd_tbl[mem_bus.addr[3:2]];
    end
  end

  // Monitor: checks completed beats, stability during stalls, and each done pulse.
  initial begin : monitor
    beat_t        b;
    logic [127:0] f;
    logic         stall;
    logic [65:0]  held;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (stall)
        checkOutput("stall_hold", {mem_bus.req, mem_bus.we, mem_bus.addr, mem_bus.wdata}, held);
      stall = mem_bus.req && !mem_bus.ack;
      held  = {mem_bus.req, mem_bus.we, mem_bus.addr, mem_bus.wdata};
      if (mem_bus.req && mem_bus.ack) begin
        if (exp_beats.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_beat: got addr %h we %b, expected no beat", mem_bus.addr, mem_bus.we);
        end else begin
          b = exp_beats.pop_front();
          checkOutput("beat_we", 128'(mem_bus.we), 128'(b.we));
          checkOutput("beat_addr", 128'(mem_bus.addr), 128'(b.addr));
          if (b.we) checkOutput("beat_wdata", 128'(mem_bus.wdata), 128'(b.wdata));
        end
      end
      if (done) begin
        if (exp_fill.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_done: got fill_data %h, expected no done", fill_data);
        end else begin
          f = exp_fill.pop_front();
          checkOutput("fill_data", fill_data, f);
        end
      end
    end
  end

  // One full transfer; optional poke re-strobes start while busy and in the DONE cycle.
  task automatic applyStimulus(input logic nwb, input logic [31:0] vaddr, input logic [127:0] vdata,
                               input logic [31:0] faddr, input int exp_lat, input bit poke);
    beat_t        b;
    logic [127:0] f;
    int           lat;
    if (nwb) begin
      for (int i = 0; i < 4; i++) begin
        b.we    = 1'b1;
        b.addr  = (vaddr & ~32'hF) + 32'(4 * i);
        b.wdata = vdata[32*i +: 32];
        exp_beats.push_back(b);
      end
    end
    for (int i = 0; i < 4; i++) begin
      b.we    = 1'b0;
      b.addr  = (faddr & ~32'hF) + 32'(4 * i);
      b.wdata = '0;
      exp_beats.push_back(b);
      f[32*i +: 32] = rd_tbl[i];
    end
    exp_fill.push_back(f);

    @(posedge clk);
    #1;
    start       = 1'b1;
    need_wb     = nwb;
    victim_addr = vaddr;
    victim_data = vdata;
    fill_addr   = faddr;
    @(posedge clk);
    #1;
    start = 1'b0;

    lat = 0;
    @(negedge clk);
    while (!done && lat < 400) begin
      if (poke && lat == 1) begin
        start       = 1'b1;
        need_wb     = ~nwb;
        victim_addr = 32'hDEAD_BEE0;
        fill_addr   = 32'h0BAD_F000;
        victim_data = ~vdata;
      end
      if (poke && lat == 2) start = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL done_timeout: got no done after %0d cycles, expected done", lat);
    end else if (exp_lat >= 0) begin
      checkOutput("done_latency", 128'(lat), 128'(exp_lat));
    end
    if (poke) begin
      start   = 1'b1;
      need_wb = 1'b0;
      @(negedge clk);
      start = 1'b0;
      checkOutput("start_in_done_ignored", 128'(busy), 128'(0));
    end
  endtask

  initial begin : watchdog
    #200000;
    vectors++;
    miscompares++;
    $display("[TB] FAIL watchdog: got run still active, expected completion");
    finishRun();
  end

  initial begin : main
    vectors     = 0;
    miscompares = 0;
    ack_mode    = 0;
    for (int i = 0; i < 4; i++) rd_tbl[i] = '0;
    reset       = 1'b1;
    start       = 1'b0;
    need_wb     = 1'b0;
    victim_addr = '0;
    victim_data = '0;
    fill_addr   = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_mem_port", {mem_bus.addr, mem_bus.wdata}, '0);
    reset = 1'b0;

    $display("[TB] reset then idle");
    repeat (10) begin
      @(negedge clk);
      checkOutput("idle_ctrl", {busy, done, mem_bus.req, mem_bus.we}, '0);
      checkOutput("idle_fill_data", fill_data, '0);
    end

    $display("[TB] refill only");
    for (int i = 0; i < 4; i++) rd_tbl[i] = 32'hA0 + 32'(i);
    applyStimulus(1'b0, 32'h0, '0, 32'h0000_1234, 4, 1'b0);

    $display("[TB] writeback then refill, back to back");
    for (int i = 0; i < 4; i++) rd_tbl[i] = 32'hB0 + 32'(i);
    applyStimulus(1'b1, 32'h40, {32'h44, 32'h33, 32'h22, 32'h11}, 32'h80, 8, 1'b0);

    $display("[TB] slow memory");
    ack_mode = 1;
    for (int i = 0; i < 4; i++) rd_tbl[i] = $urandom;
    applyStimulus(1'b1, 32'h2008, {$urandom, $urandom, $urandom, $urandom}, 32'h1004, -1, 1'b0);
    ack_mode = 0;

    $display("[TB] start while busy and in done");
    for (int i = 0; i < 4; i++) rd_tbl[i] = 32'hA0 + 32'(i);
    applyStimulus(1'b0, 32'h0, '0, 32'h0000_1234, 4, 1'b1);

    $display("[TB] reset mid-fill");
    for (int i = 0; i < 3; i++) exp_beats.push_back('{1'b0, 32'h200 + 32'(4 * i), 32'h0});
    @(posedge clk);
    #1;
    start     = 1'b1;
    need_wb   = 1'b0;
    fill_addr = 32'h200;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_req", 128'(mem_bus.req), 128'(0));
    checkOutput("abort_busy", 128'(busy), 128'(0));
    checkOutput("abort_fill_data", fill_data, '0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_beats_left", 128'(exp_beats.size()), 128'(0));

    $display("[TB] transfer after abort");
    for (int i = 0; i < 4; i++) rd_tbl[i] = 32'hC0 + 32'(i);
    applyStimulus(1'b1, 32'h40, {32'h44, 32'h33, 32'h22, 32'h11}, 32'h40, 8, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("final_beats_left", 128'(exp_beats.size()), 128'(0));
    checkOutput("final_fills_left", 128'(exp_fill.size()), 128'(0));
    finishRun();
  end

endmodule
